// File: rtl/reg_bank_initiator.sv
// reg_bank_initiator: single-beat bus initiator for a bank of DW-bit registers.
// Takes one read/write command on a valid/ready request channel and generates
// one clean chip-select/strobe cycle. It captures read data and returns the
// result on a valid/ready response channel. All outputs come from flops.
//
// Optional feature macro: READBACK_VERIFY_EN
//   When defined, every write is followed by a one-cycle read-back (VERIFY).
//   A mismatch with the written data sets rsp_err, and rsp_rdata then carries
//   the value that was read back.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a command
// ACCESS | one strobe cycle to the addressed register
// VERIFY | read-back strobe after a write (READBACK_VERIFY_EN only)
// RESP   | rsp_valid high, holding the response until rsp_ready
module reg_bank_initiator #(
    parameter int DW    = 16,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic [NREGS-1:0] reg_cs,
    output logic             reg_w,
    output logic             reg_r,
    output logic [DW-1:0]    reg_din,
    input  logic [DW-1:0]    reg_dout
);

`ifdef READBACK_VERIFY_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, VERIFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    localparam logic [NREGS-1:0] CS_ONE = NREGS'(1);
    localparam int unsigned      NREGS_U = NREGS;

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [NREGS-1:0] reg_cs_q, reg_cs_d;
    logic             reg_w_q, reg_w_d;
    logic             reg_r_q, reg_r_d;
    logic [DW-1:0]    reg_din_q, reg_din_d;
    logic             we_q, we_d;
    logic             addr_in_range;

`ifdef READBACK_VERIFY_EN
    // Address and write data are otherwise held in reg_cs/reg_din only for
    // the strobe cycle. VERIFY needs its own copies after the strobes drop.
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
`endif

    assign addr_in_range = (32'(req_addr) < NREGS_U);

    // State and output registers; reset drops every strobe asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_cs_q    <= '0;
            reg_w_q     <= 1'b0;
            reg_r_q     <= 1'b0;
            reg_din_q   <= '0;
            we_q        <= 1'b0;
`ifdef READBACK_VERIFY_EN
            addr_q      <= '0;
            wdata_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            reg_cs_q    <= reg_cs_d;
            reg_w_q     <= reg_w_d;
            reg_r_q     <= reg_r_d;
            reg_din_q   <= reg_din_d;
            we_q        <= we_d;
`ifdef READBACK_VERIFY_EN
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`endif
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        reg_cs_d    = '0;
        reg_w_d     = 1'b0;
        reg_r_d     = 1'b0;
        reg_din_d   = '0;
        we_d        = we_q;
`ifdef READBACK_VERIFY_EN
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    we_d        = req_we;
`ifdef READBACK_VERIFY_EN
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
`endif
                    req_ready_d = 1'b0;
                    rsp_rdata_d = '0;
                    if (addr_in_range) begin
                        state_d   = ACCESS;
                        rsp_err_d = 1'b0;
                        reg_cs_d  = CS_ONE << req_addr;
                        reg_w_d   = req_we;
                        reg_r_d   = ~req_we;
                        reg_din_d = req_we ? req_wdata : '0;
                    end else begin
                        // Out of range: skip the bus entirely.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rsp_rdata_d = reg_dout;
                end
`ifdef READBACK_VERIFY_EN
                if (we_q) begin
                    state_d  = VERIFY;
                    reg_cs_d = CS_ONE << addr_q;
                    reg_r_d  = 1'b1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end
`else
                state_d     = RESP;
                rsp_valid_d = 1'b1;
`endif
            end
`ifdef READBACK_VERIFY_EN
            VERIFY: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (reg_dout != wdata_q) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = reg_dout;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_cs    = reg_cs_q;
    assign reg_w     = reg_w_q;
    assign reg_r     = reg_r_q;
    assign reg_din   = reg_din_q;

endmodule

// File: tb/tb_reg_bank_initiator.sv
// Directed bench for reg_bank_initiator, built with NREGS = 3 so that address 3
// is out of range. A behavioural register bank with an optional stuck-at-0
// bit 0 answers the strobes.
module tb_reg_bank_initiator;

    localparam int DW    = 16;
    localparam int NREGS = 3;
    localparam int AW    = 2;
`ifdef READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [NREGS-1:0] reg_cs;
    logic             reg_w;
    logic             reg_r;
    logic [DW-1:0]    reg_din;
    logic [DW-1:0]    reg_dout;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [NREGS];
    logic          stuck0 = 1'b0;

    reg_bank_initiator #(.DW(DW), .NREGS(NREGS), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .reg_cs    (reg_cs),
        .reg_w     (reg_w),
        .reg_r     (reg_r),
        .reg_din   (reg_din),
        .reg_dout  (reg_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_w) begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_cs[i]) mem[i] <= reg_din;
            end
        end
    end

    always_comb begin
        reg_dout = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_cs[i]) reg_dout = mem[i];
        end
        if (stuck0) reg_dout[0] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check strobes cycle by cycle and the response.
    task automatic run_cmd(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [NREGS-1:0] exp_cs,
                           input logic [DW-1:0] exp_rdata, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        check({tag, " req_ready_busy"}, 32'(req_ready), 32'd0);
        if (exp_cs != '0) begin
            check({tag, " cs"}, 32'(reg_cs), 32'(exp_cs));
            check({tag, " w"}, 32'(reg_w), 32'(we));
            check({tag, " r"}, 32'(reg_r), 32'(!we));
            check({tag, " din"}, 32'(reg_din), we ? 32'(wdata) : 32'd0);
            check({tag, " valid_early"}, 32'(rsp_valid), 32'd0);
            tick();
            if (VERIFY && we) begin
                check({tag, " vfy_cs"}, 32'(reg_cs), 32'(exp_cs));
                check({tag, " vfy_rw"}, {30'd0, reg_w, reg_r}, 32'd1);
                tick();
            end
        end
        check({tag, " cs_idle"}, 32'(reg_cs), 32'd0);
        check({tag, " strobes_idle"}, {30'd0, reg_w, reg_r}, 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, " req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        #12;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst cs", 32'(reg_cs), 32'd0);
        check("rst strobes", {30'd0, reg_w, reg_r}, 32'd0);
        check("rst din", 32'(reg_din), 32'd0);
        rst = 1'b0;
        tick();

        run_cmd("wr2", 1'b1, 2'd2, 16'hA5C3, 3'b100, 16'h0000, 1'b0);
        check("mem2", 32'(mem[2]), 32'h0000A5C3);
        run_cmd("rd2", 1'b0, 2'd2, 16'hFFFF, 3'b100, 16'hA5C3, 1'b0);
        run_cmd("wr0", 1'b1, 2'd0, 16'h1234, 3'b001, 16'h0000, 1'b0);
        run_cmd("wr1", 1'b1, 2'd1, 16'h0F0F, 3'b010, 16'h0000, 1'b0);
        run_cmd("rd0", 1'b0, 2'd0, 16'h0000, 3'b001, 16'h1234, 1'b0);
        run_cmd("rd1", 1'b0, 2'd1, 16'h0000, 3'b010, 16'h0F0F, 1'b0);

        // Backpressure: the response must hold, and a new write must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 2'd2;
        tick();
        req_we    = 1'b1;
        req_addr  = 2'd0;
        req_wdata = 16'hDEAD;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_rdata", 32'(rsp_rdata), 32'h0000A5C3);
            check("bp rsp_err", 32'(rsp_err), 32'd0);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp cs", 32'(reg_cs), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp released", 32'(rsp_valid), 32'd0);
        run_cmd("rd0_after_bp", 1'b0, 2'd0, 16'h0000, 3'b001, 16'h1234, 1'b0);

        run_cmd("rd3_oor", 1'b0, 2'd3, 16'h0000, 3'b000, 16'h0000, 1'b1);
        run_cmd("wr3_oor", 1'b1, 2'd3, 16'h5555, 3'b000, 16'h0000, 1'b1);
        run_cmd("rd2_intact", 1'b0, 2'd2, 16'h0000, 3'b100, 16'hA5C3, 1'b0);

        stuck0 = 1'b1;
        run_cmd("wr1_stuck", 1'b1, 2'd1, 16'h0001, 3'b010, 16'h0000, VERIFY);
        stuck0 = 1'b0;

        // Reset during ACCESS: strobes and the pending response must vanish at once.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 2'd0;
        req_wdata = 16'hBEEF;
        tick();
        req_valid = 1'b0;
        check("mid cs_before", 32'(reg_cs), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid cs", 32'(reg_cs), 32'd0);
        check("mid w", 32'(reg_w), 32'd0);
        check("mid din", 32'(reg_din), 32'd0);
        check("mid req_ready", 32'(req_ready), 32'd1);
        check("mid rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst idle", 32'(rsp_valid), 32'd0);
        run_cmd("rd1_post", 1'b0, 2'd1, 16'h0000, 3'b010, 16'h0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
